timer_tick_service: RTL and testbench

Downstream consumer of the interval timer's `irq`. Detects each timeout and acknowledges it by writing the timer's status register over a 16-bit Avalon-MM master port. Counts ticks, divides them into frame events, and exposes count, divider, control and frame-interrupt state to the CPU through a 32-bit Avalon-MM slave. Removes per-tick interrupt servicing from software; the CPU sees only the divided frame interrupt.

---
 rtl/timer_tick_service.sv | 141 ++++++++++++++
 tb/tb_timer_tick_service.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_tick_service.sv
// Services the interval timer's per-tick interrupt in hardware: acknowledges it over an
// Avalon-MM master, counts ticks, divides them into frame interrupts for the CPU.
`timescale 1ns / 1ps

module timer_tick_service #(
  parameter int unsigned TIMER_STATUS_ADDR = 0,
  parameter int unsigned DIV_WIDTH         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        timer_irq,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [15:0] m_writedata,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        tick,
  output logic        frame_tick,
  output logic        irq
);

  localparam logic [2:0] StatusAddr = 3'(TIMER_STATUS_ADDR);

  typedef enum logic [1:0] {StIdle, StAck, StWait} state_e;

  state_e                state_q, state_d;
  logic [31:0]           tick_count_q, tick_count_d;
  logic [DIV_WIDTH-1:0]  divider_q, divider_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic                  enable_q, enable_d;
  logic                  frame_irq_en_q, frame_irq_en_d;
  logic                  frame_pending_q, frame_pending_d;
  logic [7:0]            overrun_q, overrun_d;
  logic                  tick_q, tick_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [31:0]           rdata_q, rdata_d;

  logic        ack_done, frame, rd_en;
  logic        cnt_wr, div_wr, ctrl_wr, stat_wr;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign unused_wdata = ^s_writedata;

  always_comb begin
    rd_en    = s_chipselect && s_read;
    cnt_wr   = s_chipselect && s_write && (s_address == 2'd0);
    div_wr   = s_chipselect && s_write && (s_address == 2'd1);
    ctrl_wr  = s_chipselect && s_write && (s_address == 2'd2);
    stat_wr  = s_chipselect && s_write && (s_address == 2'd3);
    ack_done = (state_q == StAck);
    // A divider write in the tick cycle restarts the division, so no frame fires.
    frame    = ack_done && (div_cnt_q == divider_q) && !div_wr;

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (timer_irq && enable_q) state_d = StAck;
      StAck:   state_d = StWait;
      StWait:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    tick_d       = ack_done;
    frame_tick_d = frame;

    tick_count_d = tick_count_q;
    if (cnt_wr)        tick_count_d = '0;
    else if (ack_done) tick_count_d = tick_count_q + 32'd1;

    divider_d = div_wr ? s_writedata[DIV_WIDTH-1:0] : divider_q;

    div_cnt_d = div_cnt_q;
    if (div_wr)        div_cnt_d = '0;
    else if (frame)    div_cnt_d = '0;
    else if (ack_done) div_cnt_d = div_cnt_q + 1'b1;

    enable_d       = ctrl_wr ? s_writedata[0] : enable_q;
    frame_irq_en_d = ctrl_wr ? s_writedata[1] : frame_irq_en_q;

    frame_pending_d = frame_pending_q;
    if (frame)                          frame_pending_d = 1'b1;
    else if (stat_wr && s_writedata[0]) frame_pending_d = 1'b0;

    overrun_d = overrun_q;
    if (stat_wr && s_writedata[1])
      overrun_d = '0;
    else if (frame && frame_pending_q && (overrun_q != 8'hFF))
      overrun_d = overrun_q + 8'd1;

    unique case (s_address)
      2'd0:    rd_mux = tick_count_q;
      2'd1:    rd_mux = 32'(divider_q);
      2'd2:    rd_mux = {30'd0, frame_irq_en_q, enable_q};
      default: rd_mux = {16'd0, overrun_q, 7'd0, frame_pending_q};
    endcase
    rdata_d = rd_en ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      tick_count_q    <= '0;
      divider_q       <= '0;
      div_cnt_q       <= '0;
      enable_q        <= 1'b0;
      frame_irq_en_q  <= 1'b0;
      frame_pending_q <= 1'b0;
      overrun_q       <= '0;
      tick_q          <= 1'b0;
      frame_tick_q    <= 1'b0;
      rdata_q         <= '0;
    end else begin
      state_q         <= state_d;
      tick_count_q    <= tick_count_d;
      divider_q       <= divider_d;
      div_cnt_q       <= div_cnt_d;
      enable_q        <= enable_d;
      frame_irq_en_q  <= frame_irq_en_d;
      frame_pending_q <= frame_pending_d;
      overrun_q       <= overrun_d;
      tick_q          <= tick_d;
      frame_tick_q    <= frame_tick_d;
      rdata_q         <= rdata_d;
    end
  end

  assign m_chipselect = (state_q == StAck);
  assign m_write_n    = (state_q != StAck);
  assign m_address    = (state_q == StAck) ? StatusAddr : 3'd0;
  assign m_writedata  = 16'h0000;
  assign s_readdata   = rdata_q;
  assign tick         = tick_q;
  assign frame_tick   = frame_tick_q;
  assign irq          = frame_pending_q && frame_irq_en_q;

endmodule

// File: tb/tb_timer_tick_service.sv
// Directed bench for timer_tick_service: acknowledge timing, division, wrap, enable gating
// and reset mid-sequence, with register reads checked through an expectation queue.
`timescale 1ns / 1ps

module tb_timer_tick_service;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        timer_irq = 1'b0;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [15:0] m_writedata;
  logic [1:0]  s_address = 2'd0;
  logic        s_chipselect = 1'b0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = 32'd0;
  logic [31:0] s_readdata;
  logic        tick;
  logic        frame_tick;
  logic        irq;

  timer_tick_service dut (
    .clk          (clk),
    .reset        (reset),
    .timer_irq    (timer_irq),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .tick         (tick),
    .frame_tick   (frame_tick),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  // Bus monitor: writes seen, back-to-back writes, tick pulses.
  int  wr_cnt = 0, dbl_cnt = 0, tick_cnt = 0;
  bit  prev_wr = 1'b0;
  always @(posedge clk) begin
    wr_cnt   <= wr_cnt + int'(m_chipselect && !m_write_n);
    dbl_cnt  <= dbl_cnt + int'(m_chipselect && !m_write_n && prev_wr);
    tick_cnt <= tick_cnt + int'(tick);
    prev_wr  <= m_chipselect && !m_write_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    step();
    s_chipselect = 1'b0; s_write = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    step();
    s_chipselect = 1'b0; s_read = 1'b0;
    check(tag_q.pop_front(), s_readdata, exp_q.pop_front());
  endtask

  // One timeout: raise irq, wait (bounded) for the acknowledge, drop irq, check the pulses.
  task automatic timeout(input bit exp_frame, input string tag);
    int w = 0;
    timer_irq = 1'b1;
    step();
    while (!m_chipselect && w < 10) begin
      step();
      w++;
    end
    check({tag, "_ack"}, 32'(m_chipselect), 32'd1);
    timer_irq = 1'b0;
    step();
    check({tag, "_tick"}, 32'(tick), 32'd1);
    check({tag, "_frame"}, 32'(frame_tick), 32'(exp_frame));
    step();
  endtask

  initial begin
    int base_wr, base_dbl, base_tick;

    // Reset state
    step(2);
    check("rst_cs", 32'(m_chipselect), 32'd0);
    check("rst_wn", 32'(m_write_n), 32'd1);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_frame", 32'(frame_tick), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", s_readdata, 32'd0);
    reset = 1'b0;
    step();

    // Single tick, divider 0: exact acknowledge/tick latency
    reg_write(2'd2, 32'h1);
    reg_write(2'd1, 32'h0);
    base_wr = wr_cnt;
    timer_irq = 1'b1;
    step();
    check("t1_cs", 32'(m_chipselect), 32'd1);
    check("t1_wn", 32'(m_write_n), 32'd0);
    check("t1_addr", 32'(m_address), 32'd0);
    check("t1_wdata", 32'(m_writedata), 32'd0);
    timer_irq = 1'b0;
    step();
    check("t1_tick", 32'(tick), 32'd1);
    check("t1_frame", 32'(frame_tick), 32'd1);
    check("t1_cs_off", 32'(m_chipselect), 32'd0);
    check("t1_irq", 32'(irq), 32'd0);
    step();
    check("t1_tick_off", 32'(tick), 32'd0);
    check("t1_writes", 32'(wr_cnt - base_wr), 32'd1);
    reg_read(2'd0, 32'd1, "t1_count");
    reg_read(2'd3, 32'h1, "t1_status");

    // Divide by 4, eight timeouts, overrun on the second frame
    reg_write(2'd3, 32'h3);
    reg_write(2'd1, 32'd3);
    reg_write(2'd2, 32'h3);
    reg_write(2'd0, 32'h0);
    reg_read(2'd1, 32'd3, "t2_divider");
    reg_read(2'd2, 32'h3, "t2_control");
    for (int i = 0; i < 8; i++) begin
      timeout(((i + 1) % 4) == 0, $sformatf("t2_%0d", i));
      check($sformatf("t2_irq_%0d", i), 32'(irq), 32'(i >= 3));
    end
    reg_read(2'd0, 32'd8, "t2_count");
    reg_read(2'd3, 32'h0101, "t2_status");
    reg_write(2'd3, 32'h3);
    reg_read(2'd3, 32'h0, "t2_status_clr");
    check("t2_irq_clr", 32'(irq), 32'd0);

    // Continuous irq: one service per 3 cycles
    reg_write(2'd0, 32'h0);
    base_wr = wr_cnt; base_dbl = dbl_cnt; base_tick = tick_cnt;
    timer_irq = 1'b1;
    step(30);
    timer_irq = 1'b0;
    step(3);
    check("t3_writes", 32'(wr_cnt - base_wr), 32'd10);
    check("t3_double", 32'(dbl_cnt - base_dbl), 32'd0);
    check("t3_ticks", 32'(tick_cnt - base_tick), 32'd10);
    reg_read(2'd0, 32'd10, "t3_count");

    // Wrap, same-cycle clear, same-cycle divider write
    reg_write(2'd1, 32'd0);
    force dut.tick_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.tick_count_q;
    reg_read(2'd0, 32'hFFFF_FFFF, "t4_preload");
    timeout(1'b1, "t4_wrap");
    reg_read(2'd0, 32'd0, "t4_wrapped");
    timeout(1'b1, "t4_one");
    timer_irq = 1'b1;
    step();
    timer_irq = 1'b0;
    s_chipselect = 1'b1; s_write = 1'b1; s_address = 2'd0; s_writedata = 32'd0;
    step();
    s_chipselect = 1'b0; s_write = 1'b0;
    check("t4_clr_tick", 32'(tick), 32'd1);
    step();
    reg_read(2'd0, 32'd0, "t4_clr_wins");
    timer_irq = 1'b1;
    step();
    timer_irq = 1'b0;
    s_chipselect = 1'b1; s_write = 1'b1; s_address = 2'd1; s_writedata = 32'd0;
    step();
    s_chipselect = 1'b0; s_write = 1'b0;
    check("t4_divwr_tick", 32'(tick), 32'd1);
    check("t4_divwr_frame", 32'(frame_tick), 32'd0);
    step();

    // Disabled: irq held high, no service until re-enabled
    reg_write(2'd2, 32'h0);
    base_wr = wr_cnt;
    timer_irq = 1'b1;
    step(10);
    check("t5_no_writes", 32'(wr_cnt - base_wr), 32'd0);
    reg_read(2'd0, 32'd1, "t5_count");
    reg_write(2'd2, 32'h1);
    step();
    check("t5_resume", 32'(m_chipselect), 32'd1);
    timer_irq = 1'b0;
    step(2);
    reg_read(2'd0, 32'd2, "t5_count2");

    // Reset during the acknowledge cycle
    reg_write(2'd2, 32'h3);
    reg_write(2'd1, 32'd5);
    timer_irq = 1'b1;
    step();
    check("t6_in_ack", 32'(m_chipselect), 32'd1);
    reset = 1'b1;
    timer_irq = 1'b0;
    step();
    check("t6_cs", 32'(m_chipselect), 32'd0);
    check("t6_wn", 32'(m_write_n), 32'd1);
    check("t6_tick", 32'(tick), 32'd0);
    check("t6_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    reg_read(2'd0, 32'd0, "t6_count");
    reg_read(2'd1, 32'd0, "t6_divider");
    reg_read(2'd2, 32'd0, "t6_control");
    reg_read(2'd3, 32'd0, "t6_status");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
